// File: rtl/univ_shift_reg_if.sv
// Mode/serial/parallel inputs and register/detector outputs of univ_shift_reg.
// The clock C and reset R stay plain module ports.
interface univ_shift_reg_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 4
);
   logic [1:0]       S;
   logic             SI_UP;
   logic             SI_DN;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             SO;
   logic             MATCH;
   logic [CNT_W-1:0] MCNT;

   modport master (
      output S, SI_UP, SI_DN, D,
      input  Q, SO, MATCH, MCNT
   );

   modport slave (
      input  S, SI_UP, SI_DN, D,
      output Q, SO, MATCH, MCNT
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift up / shift down / load) with a
// pattern detector and a saturating counter of matching shift results.
module univ_shift_reg #(
   parameter int unsigned      WIDTH   = 4,
   parameter logic [WIDTH-1:0] PATTERN = WIDTH'(4'b1011),
   parameter int unsigned      CNT_W   = 4
) (
   input logic                  C,
   input logic                  R,
   univ_shift_reg_if.slave      bus
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DN   = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   mode_e            mode;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_next;
   logic [CNT_W-1:0] cnt;
   logic             shifting;
   logic             so;

   assign mode = mode_e'(bus.S);

   always_comb begin
      q_next   = q;
      shifting = 1'b0;
      case (mode)
         MODE_HOLD: q_next = q;
         MODE_UP: begin
            q_next   = {q[WIDTH-2:0], bus.SI_UP};
            shifting = 1'b1;
         end
         MODE_DN: begin
            q_next   = {bus.SI_DN, q[WIDTH-1:1]};
            shifting = 1'b1;
         end
         MODE_LOAD: q_next = bus.D;
         default:   q_next = q;
      endcase
   end

   // Only shift results are counted; the counter sticks at all ones.
   always_ff @(posedge C) begin
      if (R) begin
         q   <= '0;
         cnt <= '0;
      end else begin
         q <= q_next;
         if (shifting && (q_next == PATTERN) && (cnt != '1))
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      so = 1'b0;
      case (mode)
         MODE_UP: so = q[WIDTH-1];
         MODE_DN: so = q[0];
         default: so = 1'b0;
      endcase
   end

   assign bus.Q     = q;
   assign bus.SO    = so;
   assign bus.MATCH = (q == PATTERN);
   assign bus.MCNT  = cnt;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: two DUTs (PATTERN 1011 and 1111) share one stimulus stream;
// an arithmetic reference model queues expectations checked by a monitor.
module tb_univ_shift_reg;

   logic C = 1'b0;
   logic R = 1'b0;

   univ_shift_reg_if #(.WIDTH(4), .CNT_W(4)) bif_a ();
   univ_shift_reg_if #(.WIDTH(4), .CNT_W(4)) bif_b ();

   univ_shift_reg #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(4)) dut_a (
      .C(C), .R(R), .bus(bif_a)
   );
   univ_shift_reg #(.WIDTH(4), .PATTERN(4'b1111), .CNT_W(4)) dut_b (
      .C(C), .R(R), .bus(bif_b)
   );

   always #5 C = ~C;

   typedef struct {
      string tag;
      int    q;
      int    so;
      int    match_a;
      int    match_b;
      int    cnt_a;
      int    cnt_b;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   int   m_q  = 0;
   int   m_ca = 0;
   int   m_cb = 0;

   task automatic check(input string name, input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s [%s]: got %0d expected %0d", name, tag, act, exp);
      end
   endtask

   task automatic apply(input string tag, input logic r, input logic [1:0] s,
                        input logic up, input logic dn, input logic [3:0] d);
      exp_t e;
      bit   shifted;
      @(negedge C);
      R           = r;
      bif_a.S     = s;  bif_b.S     = s;
      bif_a.SI_UP = up; bif_b.SI_UP = up;
      bif_a.SI_DN = dn; bif_b.SI_DN = dn;
      bif_a.D     = d;  bif_b.D     = d;
      shifted = 1'b0;
      if (r) begin
         m_q = 0; m_ca = 0; m_cb = 0;
      end else begin
         case (s)
            2'b01: begin m_q = (m_q * 2 + int'(up)) % 16; shifted = 1'b1; end
            2'b10: begin m_q = int'(dn) * 8 + m_q / 2;    shifted = 1'b1; end
            2'b11: m_q = int'(d);
            default: ;
         endcase
         if (shifted && m_q == 11 && m_ca < 15) m_ca++;
         if (shifted && m_q == 15 && m_cb < 15) m_cb++;
      end
      e.tag     = tag;
      e.q       = m_q;
      e.so      = (s == 2'b01) ? (m_q / 8) : (s == 2'b10) ? (m_q % 2) : 0;
      e.match_a = (m_q == 11) ? 1 : 0;
      e.match_b = (m_q == 15) ? 1 : 0;
      e.cnt_a   = m_ca;
      e.cnt_b   = m_cb;
      sb.push_back(e);
   endtask

   // Monitor: every edge yields a new register state; compare 1 ns later.
   initial begin
      exp_t e;
      forever begin
         @(posedge C);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q_a",     e.tag, int'(bif_a.Q),     e.q);
            check("q_b",     e.tag, int'(bif_b.Q),     e.q);
            check("so_a",    e.tag, int'(bif_a.SO),    e.so);
            check("so_b",    e.tag, int'(bif_b.SO),    e.so);
            check("match_a", e.tag, int'(bif_a.MATCH), e.match_a);
            check("match_b", e.tag, int'(bif_b.MATCH), e.match_b);
            check("mcnt_a",  e.tag, int'(bif_a.MCNT),  e.cnt_a);
            check("mcnt_b",  e.tag, int'(bif_b.MCNT),  e.cnt_b);
         end
      end
   end

   initial begin
      logic [3:0] su;
      int         guard;
      bif_a.S = 2'b00; bif_a.SI_UP = 1'b0; bif_a.SI_DN = 1'b0; bif_a.D = 4'h0;
      bif_b.S = 2'b00; bif_b.SI_UP = 1'b0; bif_b.SI_DN = 1'b0; bif_b.D = 4'h0;

      apply("reset", 1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
      for (int unsigned i = 0; i < 3; i++) apply("idle_hold", 1'b0, 2'b00, 1'b1, 1'b1, 4'hA);

      su = 4'b1101;  // SI_UP sequence 1,0,1,1 read from bit 0 upward
      for (int unsigned i = 0; i < 4; i++) apply("shift_up", 1'b0, 2'b01, su[i], 1'b0, 4'h0);

      apply("load_0110", 1'b0, 2'b11, 1'b0, 1'b0, 4'b0110);
      apply("shift_dn", 1'b0, 2'b10, 1'b0, 1'b1, 4'h0);
      for (int unsigned i = 0; i < 5; i++) apply("hold_match", 1'b0, 2'b00, 1'b1, 1'b0, 4'h3);
      apply("load_1011", 1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);

      for (int unsigned i = 0; i < 24; i++) apply("saturate", 1'b0, 2'b01, 1'b1, 1'b0, 4'h0);

      apply("pre_reset_1", 1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
      apply("pre_reset_2", 1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
      apply("mid_reset",   1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
      apply("resume",      1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
      apply("resume",      1'b0, 2'b01, 1'b0, 1'b0, 4'h0);

      for (int unsigned i = 0; i < 300; i++)
         apply("random", ($urandom_range(31) == 0), 2'($urandom_range(3)),
               1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)));

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge C);
         guard++;
      end
      @(negedge C);
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
